// File: rtl/dm_port_arbiter_if.sv
// Bundle of the two requester ports and the data-memory control port of dm_port_arbiter.
// slave = arbiter side, master = requesters plus the memory that returns dm_a_out.
interface dm_port_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [5:0]  m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m1_req;
   logic        m1_we;
   logic [5:0]  m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;
   logic [5:0]  dm_ra;
   logic [31:0] dm_d;
   logic        dm_load;
   logic        dm_str;
   logic        dm_sel;
   logic [31:0] dm_a_out;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  dm_a_out,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output dm_ra, dm_d, dm_load, dm_str, dm_sel
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output dm_a_out,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  dm_ra, dm_d, dm_load, dm_str, dm_sel
   );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for the single data-memory port (m0 = pipeline, m1 = debug/loader) with starvation bound.
// Optional grant/wait statistics counters enabled by defining DM_ARB_STATS_EN.
module dm_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              clr_n,
   dm_port_arbiter_if.slave  bus
`ifdef DM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  m0_gnt_cnt,
   output logic [CNT_W-1:0]  m1_gnt_cnt,
   output logic [CNT_W-1:0]  m1_wait_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RD0, RD1} own_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   own_t        state_q, state_d;
   logic [3:0]  starve_q;
   logic        gnt0, gnt1, m1_pri;
   logic        rvalid0, rvalid1;
   logic [31:0] rdata0_q, rdata1_q;

   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      m1_pri = bus.m1_req && (starve_q >= STARVE_LIM);
      if (clr_n) begin
         if (m1_pri)          gnt1 = 1'b1;
         else if (bus.m0_req) gnt0 = 1'b1;
         else if (bus.m1_req) gnt1 = 1'b1;
      end
   end

   always_comb begin
      bus.dm_sel  = 1'b0;
      bus.dm_ra   = '0;
      bus.dm_d    = '0;
      bus.dm_str  = 1'b0;
      bus.dm_load = 1'b0;
      if (gnt0) begin
         bus.dm_sel  = 1'b1;
         bus.dm_ra   = bus.m0_addr;
         bus.dm_d    = bus.m0_wdata;
         bus.dm_str  = bus.m0_we;
         bus.dm_load = ~bus.m0_we;
      end else if (gnt1) begin
         bus.dm_sel  = 1'b1;
         bus.dm_ra   = bus.m1_addr;
         bus.dm_d    = bus.m1_wdata;
         bus.dm_str  = bus.m1_we;
         bus.dm_load = ~bus.m1_we;
      end
   end

   // Next owner depends only on this cycle's grant, so back-to-back reads chain through RDx.
   always_comb begin
      state_d = IDLE;
      rvalid0 = 1'b0;
      rvalid1 = 1'b0;
      if (gnt0 && !bus.m0_we)      state_d = RD0;
      else if (gnt1 && !bus.m1_we) state_d = RD1;
      case (state_q)
         RD0:     rvalid0 = 1'b1;
         RD1:     rvalid1 = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (gnt0 && !bus.m0_we) rdata0_q <= bus.dm_a_out;
         if (gnt1 && !bus.m1_we) rdata1_q <= bus.dm_a_out;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n || gnt1 || !bus.m1_req) starve_q <= '0;
      else if (starve_q != 4'd15)        starve_q <= starve_q + 4'd1;
   end

   assign bus.m0_gnt    = gnt0;
   assign bus.m1_gnt    = gnt1;
   assign bus.m0_rvalid = rvalid0;
   assign bus.m1_rvalid = rvalid1;
   assign bus.m0_rdata  = rdata0_q;
   assign bus.m1_rdata  = rdata1_q;

`ifdef DM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         m0_gnt_cnt  <= '0;
         m1_gnt_cnt  <= '0;
         m1_wait_cnt <= '0;
      end else begin
         if (gnt0)                m0_gnt_cnt  <= m0_gnt_cnt + 1'b1;
         if (gnt1)                m1_gnt_cnt  <= m1_gnt_cnt + 1'b1;
         if (bus.m1_req && !gnt1) m1_wait_cnt <= m1_wait_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios then random traffic against a reference model.
// Statistics outputs are checked when DM_ARB_STATS_EN is defined.
module tb_dm_port_arbiter;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned CNT_W      = 16;

   logic clk = 1'b0;
   logic clr_n;
   always #5 clk = ~clk;

   dm_port_arbiter_if bus();

`ifdef DM_ARB_STATS_EN
   logic [CNT_W-1:0] m0_gnt_cnt, m1_gnt_cnt, m1_wait_cnt;
`endif

   dm_port_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
`ifdef DM_ARB_STATS_EN
      ,
      .m0_gnt_cnt  (m0_gnt_cnt),
      .m1_gnt_cnt  (m1_gnt_cnt),
      .m1_wait_cnt (m1_wait_cnt)
`endif
   );

   // Data memory attached to the arbiter: combinational read, write at posedge.
   logic [31:0] dm_mem [64];
   assign bus.dm_a_out = dm_mem[bus.dm_ra];
   always @(posedge clk) if (bus.dm_sel && bus.dm_str) dm_mem[bus.dm_ra] <= bus.dm_d;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          m_wait = 0;
   bit          m_rv0 = 0, m_rv1 = 0;
   logic [31:0] m_rd0 = '0, m_rd1 = '0;
   logic [31:0] m_mem [64];
   int          m_c0 = 0, m_c1 = 0, m_cw = 0;
   bit          obs_g0, obs_g1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit clr, input bit late_clr,
                        input bit r0, input bit w0, input logic [5:0] a0, input logic [31:0] d0,
                        input bit r1, input bit w1, input logic [5:0] a1, input logic [31:0] d1);
      bit g0, g1;
      logic [31:0] xd;
      logic [5:0]  xa;
      bit          xw;
      bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
      bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
      clr_n = late_clr ? 1'b1 : clr;
      #2;
      g0 = 0; g1 = 0;
      if (clr_n) begin
         if (r1 && m_wait >= int'(STARVE_MAX)) g1 = 1;
         else if (r0)                          g0 = 1;
         else if (r1)                          g1 = 1;
      end
      obs_g0 = bus.m0_gnt;
      obs_g1 = bus.m1_gnt;
      chk("gnt", {62'd0, bus.m0_gnt, bus.m1_gnt}, {62'd0, g0, g1});
      xa = g0 ? a0 : a1;
      xd = g0 ? d0 : d1;
      xw = g0 ? w0 : w1;
      if (g0 || g1)
         chk("dm_ctrl", {bus.dm_sel, bus.dm_str, bus.dm_load, bus.dm_ra, bus.dm_d},
                        {1'b1, xw, ~xw, xa, xd});
      else
         chk("dm_idle", {bus.dm_sel, bus.dm_str, bus.dm_load, bus.dm_ra, bus.dm_d}, '0);
      if (late_clr) clr_n = 1'b0;
      @(posedge clk);
      if (!clr_n) begin
         m_wait = 0; m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
         m_c0 = 0; m_c1 = 0; m_cw = 0;
      end else begin
         m_rv0 = g0 && !w0;
         m_rv1 = g1 && !w1;
         if (m_rv0) m_rd0 = m_mem[a0];
         if (m_rv1) m_rd1 = m_mem[a1];
         if (g0 && w0) m_mem[a0] = d0;
         if (g1 && w1) m_mem[a1] = d1;
         if (g0) m_c0++;
         if (g1) m_c1++;
         if (r1 && !g1) m_cw++;
         m_wait = (g1 || !r1) ? 0 : ((m_wait < 15) ? m_wait + 1 : 15);
      end
      #1;
      chk("rvalid", {62'd0, bus.m0_rvalid, bus.m1_rvalid}, {62'd0, m_rv0, m_rv1});
      chk("m0_rdata", {32'd0, bus.m0_rdata}, {32'd0, m_rd0});
      chk("m1_rdata", {32'd0, bus.m1_rdata}, {32'd0, m_rd1});
`ifdef DM_ARB_STATS_EN
      chk("m0_gnt_cnt",  64'(m0_gnt_cnt),  64'(CNT_W'(m_c0)));
      chk("m1_gnt_cnt",  64'(m1_gnt_cnt),  64'(CNT_W'(m_c1)));
      chk("m1_wait_cnt", 64'(m1_wait_cnt), 64'(CNT_W'(m_cw)));
`endif
   endtask

   initial begin
      clr_n = 1'b0;
      bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
      @(posedge clk); #1;

      // Reset held with both masters requesting
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 6'd1, '0, 1, 0, 6'd2, '0);
      chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, '0);

      // Preload the whole memory through m0 writes
      for (int i = 0; i < 64; i++) cycle(1, 0, 1, 1, 6'(i), $urandom, 0, 0, '0, '0);

      // m0 write then m1 read of the same word
      cycle(1, 0, 1, 1, 6'd5, 32'hDEADBEEF, 0, 0, '0, '0);
      cycle(1, 0, 0, 0, '0, '0, 1, 0, 6'd5, '0);
      chk("sc2_rvalid", {63'd0, bus.m1_rvalid}, 64'd1);
      chk("sc2_rdata", {32'd0, bus.m1_rdata}, 64'hDEADBEEF);
      cycle(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);

      // Continuous contention: m1 wins every fifth cycle
      cycle(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
      for (int k = 0; k < 10; k++) begin
         cycle(1, 0, 1, 0, 6'(k), '0, 1, 0, 6'd20, '0);
         chk("sc3_pattern", {62'd0, obs_g0, obs_g1}, (k % 5 == 4) ? 64'd1 : 64'd2);
      end
`ifdef DM_ARB_STATS_EN
      chk("sc3_m0_cnt",   64'(m0_gnt_cnt),  64'd8);
      chk("sc3_m1_cnt",   64'(m1_gnt_cnt),  64'd2);
      chk("sc3_wait_cnt", 64'(m1_wait_cnt), 64'd8);
`endif
      cycle(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);

      // Same-address collision: m0 write wins, m1 read follows with new data
      cycle(1, 0, 1, 1, 6'd7, 32'h12345678, 1, 0, 6'd7, '0);
      chk("sc4_first", {62'd0, obs_g0, obs_g1}, 64'd2);
      cycle(1, 0, 0, 0, '0, '0, 1, 0, 6'd7, '0);
      chk("sc4_second", {62'd0, obs_g0, obs_g1}, 64'd1);
      chk("sc4_rdata", {32'd0, bus.m1_rdata}, 64'h12345678);

      // Read granted in the cycle whose closing edge sees reset
      cycle(1, 0, 1, 1, 6'd3, 32'hA5A50003, 0, 0, '0, '0);
      cycle(1, 0, 1, 0, 6'd3, '0, 0, 0, '0, '0);
      chk("sc5_pre_rdata", {32'd0, bus.m0_rdata}, 64'hA5A50003);
      cycle(0, 1, 1, 0, 6'd3, '0, 0, 0, '0, '0);
      chk("sc5_granted", {62'd0, obs_g0, obs_g1}, 64'd2);
      chk("sc5_rvalid", {63'd0, bus.m0_rvalid}, 64'd0);
      chk("sc5_rdata", {32'd0, bus.m0_rdata}, 64'd0);
      cycle(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
      chk("sc5_after", {63'd0, bus.m0_rvalid}, 64'd0);

      // Random traffic over a small address window to provoke collisions
      for (int n = 0; n < 400; n++) begin
         bit rc, lc;
         rc = ($urandom_range(0, 49) != 0);
         lc = ($urandom_range(0, 49) == 0);
         cycle(rc, lc,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
